// File: rtl/vram_wr_mux_pkg.sv
// ============================================================================
// Module      : vram_wr_mux_pkg
// Description : Shared vdp99 VRAM constants for the CPU write path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vram_wr_mux_pkg;

    localparam int VRAM_AW = 14;
    localparam int VRAM_DW = 8;

    // Counter width able to hold the values 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vram_wr_fifo.sv
// ============================================================================
// Module      : vram_wr_fifo
// Description : Synchronous FIFO for queued VRAM writes {address, data}.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vram_wr_fifo
    import vram_wr_mux_pkg::*;
#(
    parameter int WIDTH = VRAM_AW + VRAM_DW,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);
    localparam logic [CW-1:0] c_cnt_full = CW'(DEPTH);

    logic [IW-1:0]    wr_q;
    logic [IW-1:0]    rd_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + IW'(1);
            if (pop)  rd_q <= rd_q + IW'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // When full with a same-clock pop, wr_q equals rd_q; the head is read
    // out before this edge overwrites it.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= din;
    end

    assign dout  = mem_q[rd_q];
    assign full  = (cnt_q == c_cnt_full);
    assign empty = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/vram_wr_mux.sv
// ============================================================================
// Module      : vram_wr_mux
// Description : vdp99 CPU-to-VRAM write path: address pointer, write queue
//               and slot-timed VRAM write strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vram_wr_mux
    import vram_wr_mux_pkg::*;
#(
    parameter int AW    = VRAM_AW,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 addr_ld,
    input  logic [AW-1:0]        addr_in,
    input  logic                 wr_tick,
    input  logic [VRAM_DW-1:0]   din,
    input  logic                 slot_tick,
    output logic                 vram_we,
    output logic [AW-1:0]        vram_addr,
    output logic [VRAM_DW-1:0]   vram_dout,
    output logic                 full,
    output logic                 empty,
    output logic                 ovf
);

    localparam int EW = AW + VRAM_DW;

    logic [AW-1:0]      ptr_q;
    logic [AW-1:0]      ptr_d;
    logic               ovf_q;
    logic               ovf_d;
    logic               we_q;
    logic [AW-1:0]      addr_q;
    logic [VRAM_DW-1:0] data_q;

    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic [AW-1:0]      w_eff_addr;
    logic [EW-1:0]      w_head;

    assign w_pop      = slot_tick & ~w_empty;
    // A pop in the same clock frees an entry, so a full queue still accepts.
    assign w_push     = wr_tick & (~w_full | w_pop);
    assign w_drop     = wr_tick & ~w_push;
    assign w_eff_addr = addr_ld ? addr_in : ptr_q;

    always_comb begin
        ptr_d = ptr_q;
        if (w_push) begin
            ptr_d = w_eff_addr + AW'(1);
        end else if (addr_ld) begin
            ptr_d = addr_in;
        end

        ovf_d = ovf_q;
        if (addr_ld) begin
            ovf_d = 1'b0;
        end else if (w_drop) begin
            ovf_d = 1'b1;
        end
    end

    vram_wr_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   ({w_eff_addr, din}),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q  <= '0;
            ovf_q  <= 1'b0;
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            ovf_q <= ovf_d;
            we_q  <= w_pop;
            if (w_pop) begin
                addr_q <= w_head[EW-1:VRAM_DW];
                data_q <= w_head[VRAM_DW-1:0];
            end
        end
    end

    assign vram_we   = we_q;
    assign vram_addr = addr_q;
    assign vram_dout = data_q;
    assign full      = w_full;
    assign empty     = w_empty;
    assign ovf       = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_vram_wr_mux.sv
// ============================================================================
// Module      : tb_vram_wr_mux
// Description : Scoreboard bench for vram_wr_mux against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vram_wr_mux;

    localparam int AW    = 14;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [7:0]    d;
    } ent_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          addr_ld;
    logic [AW-1:0] addr_in;
    logic          wr_tick;
    logic [7:0]    din;
    logic          slot_tick;
    logic          vram_we;
    logic [AW-1:0] vram_addr;
    logic [7:0]    vram_dout;
    logic          full;
    logic          empty;
    logic          ovf;

    always #5 clk = ~clk;

    vram_wr_mux #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .addr_ld   (addr_ld),
        .addr_in   (addr_in),
        .wr_tick   (wr_tick),
        .din       (din),
        .slot_tick (slot_tick),
        .vram_we   (vram_we),
        .vram_addr (vram_addr),
        .vram_dout (vram_dout),
        .full      (full),
        .empty     (empty),
        .ovf       (ovf)
    );

    // Reference model state: pending queue, expected strobes, pointer, flags.
    ent_t          mq[$];
    ent_t          exp_q[$];
    ent_t          last;
    logic [AW-1:0] m_ptr;
    logic          m_ovf;
    logic          m_we;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        exp_q.delete();
        last  = '0;
        m_ptr = '0;
        m_ovf = 1'b0;
        m_we  = 1'b0;
    endtask

    // Applies the write-path rules to the inputs seen at this clock edge.
    task automatic model_edge();
        bit            was_full;
        bit            pop;
        bit            acc;
        logic [AW-1:0] eff;
        was_full = (mq.size() == DEPTH);
        pop      = slot_tick && (mq.size() != 0);
        eff      = addr_ld ? addr_in : m_ptr;
        acc      = wr_tick && (!was_full || pop);
        m_we     = pop;
        if (pop) exp_q.push_back(mq.pop_front());
        if (acc) begin
            mq.push_back({eff, din});
            m_ptr = eff + 14'd1;
        end else if (addr_ld) begin
            m_ptr = addr_in;
        end
        if (addr_ld) m_ovf = 1'b0;
        else if (wr_tick && !acc) m_ovf = 1'b1;
    endtask

    task automatic step(input logic ld, input logic [AW-1:0] a, input logic wr,
                        input logic [7:0] d, input logic sl);
        addr_ld   = ld;
        addr_in   = a;
        wr_tick   = wr;
        din       = d;
        slot_tick = sl;
        @(posedge clk);
        model_edge();
        #1;
        addr_ld   = 1'b0;
        addr_in   = '0;
        wr_tick   = 1'b0;
        din       = '0;
        slot_tick = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic slots(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 8'h00, 1'b1);
    endtask

    // Asynchronous reset placed between edges, after the monitor has sampled.
    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("rst_we",    vram_we,   0);
        chk("rst_addr",  vram_addr, 0);
        chk("rst_dout",  vram_dout, 0);
        chk("rst_empty", empty,     1);
        chk("rst_full",  full,      0);
        chk("rst_ovf",   ovf,       0);
        model_clear();
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    always @(negedge clk) begin
        chk("we", vram_we, m_we);
        if (vram_we && exp_q.size() != 0) last = exp_q.pop_front();
        chk("vram_addr", vram_addr, last.a);
        chk("vram_dout", vram_dout, last.d);
        chk("full",  full,  mq.size() == DEPTH);
        chk("empty", empty, mq.size() == 0);
        chk("ovf",   ovf,   m_ovf);
    end

    initial begin
        reset     = 1'b0;
        addr_ld   = 1'b0;
        addr_in   = '0;
        wr_tick   = 1'b0;
        din       = '0;
        slot_tick = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        idle(20);

        // Basic transfer with a slot every third clock
        step(1'b1, 14'h1234, 1'b1, 8'hA5, 1'b0);
        step(1'b0, '0,       1'b1, 8'h5A, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b0, '0, 1'b0, 8'h00, (i % 3) == 2);
        idle(2);

        // Pointer wrap
        step(1'b1, 14'h3FFF, 1'b1, 8'h11, 1'b0);
        step(1'b0, '0,       1'b1, 8'h22, 1'b0);
        slots(2);
        idle(2);

        // Overflow and recovery
        step(1'b1, 14'h0100, 1'b0, 8'h00, 1'b0);
        for (int i = 1; i <= 5; i++) step(1'b0, '0, 1'b1, 8'(i), 1'b0);
        chk("t4_full", full, 1);
        chk("t4_ovf",  ovf,  1);
        slots(4);
        step(1'b0, '0, 1'b1, 8'h06, 1'b0);
        slots(1);
        idle(1);
        chk("t4_ovf_sticky", ovf, 1);
        step(1'b1, 14'h0000, 1'b0, 8'h00, 1'b0);
        chk("t4_ovf_clr", ovf, 0);

        // Simultaneous push and pop on a full queue
        step(1'b1, 14'h0300, 1'b1, 8'hC0, 1'b0);
        for (int i = 1; i < 4; i++) step(1'b0, '0, 1'b1, 8'(8'hC0 + i), 1'b0);
        step(1'b0, '0, 1'b1, 8'h77, 1'b1);
        chk("t5_full", full, 1);
        chk("t5_ovf",  ovf,  0);
        slots(5);
        idle(1);

        // Load and write in the same clock, then reset mid-queue
        step(1'b1, 14'h0010, 1'b0, 8'h00, 1'b0);
        step(1'b1, 14'h0200, 1'b1, 8'h99, 1'b0);
        step(1'b0, '0,       1'b1, 8'h42, 1'b0);
        slots(2);
        idle(1);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 8'(8'hE0 + i), 1'b0);
        slots(1);
        do_reset();
        idle(5);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(499, 0) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(15, 0) == 0, AW'($urandom),
                     $urandom_range(1, 0) == 1, 8'($urandom),
                     $urandom_range(2, 0) == 0);
            end
        end

        slots(DEPTH + 2);
        @(negedge clk);
        #1;
        chk("drain", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
